// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall controller:
//                FSM state encoding, default parameters, and the per-stage
//                control word with its canonical values.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_stall_ctrl_pkg;

  // Default sizing for the controller.
  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W       = 16;

  // Controller FSM, 2-bit encoding.
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_e;

  // ID/EXE NOP control word: WB_EN=0, MEM_R_EN=0, MEM_W_EN=0.
  localparam logic [2:0] C_ID_EX_NOP_CTRL = 3'b000;

  // Per-stage control bundle driven towards the pipeline registers.
  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
  } stall_ctl_t;

  // Nothing held, nothing squashed.
  localparam stall_ctl_t C_CTL_NONE      = '{default: 1'b0};
  // Memory stall: whole pipe holds; front-end holds explicitly as well.
  localparam stall_ctl_t C_CTL_MEM_STALL = '{pc_freeze: 1'b1, if_id_freeze: 1'b1,
                                             if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                             pipe_freeze: 1'b1};
  // Taken branch: PC loads the target, IF/ID and ID/EXE are squashed.
  localparam stall_ctl_t C_CTL_BRANCH    = '{pc_freeze: 1'b0, if_id_freeze: 1'b0,
                                             if_id_flush: 1'b1, id_ex_bubble: 1'b1,
                                             pipe_freeze: 1'b0};
  // ID hazard: front-end holds, a bubble enters EXE.
  localparam stall_ctl_t C_CTL_HAZARD    = '{pc_freeze: 1'b1, if_id_freeze: 1'b1,
                                             if_id_flush: 1'b0, id_ex_bubble: 1'b1,
                                             pipe_freeze: 1'b0};

endpackage : pipeline_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl_if
//  Description : Bundle between the pipeline datapath (master) and the stall
//                controller (slave): hazard/branch/memory status in, per-stage
//                freeze/flush/bubble controls and performance counters out.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);

  // Status from the pipeline stages.
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  // Controls and readout from the controller.
  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output hazard_detected, branch_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze,
    input  mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze,
    output mem_timeout, stall_cycles, flush_events
  );

endinterface : pipeline_stall_ctrl_if
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that increments on inc and holds at its
//                all-ones value instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         inc,
  output logic      [W-1:0] count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next value: step by one unless already pinned at the maximum.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != C_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Converts ID hazards, EXE taken branches and multicycle MEM
//                waits into per-stage freeze/flush/bubble controls. A watchdog
//                traps memory waits longer than MEM_TIMEOUT, and two saturating
//                counters track stall cycles and flush events.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int               WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] C_WAIT_ONE = WAIT_W'(1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;

  logic                w_mem_ack;
  logic                w_mem_stall;
  stall_ctl_t          w_ctl;
  logic                w_stall_inc;
  logic                w_flush_inc;

  // A completion only counts while the MEM stage actually holds a request;
  // a dropped request during a wait is treated as still not ready.
  assign w_mem_ack = bus.mem_req & bus.mem_ready;

  // Stall raised by the memory side in the current cycle.
  assign w_mem_stall = ((state_q == S_RUN)      & bus.mem_req & ~bus.mem_ready) |
                       ((state_q == S_MEM_WAIT) & ~w_mem_ack)                    |
                        (state_q == S_ERROR);

  // State, wait counter and timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic: memory wait tracking and the timeout watchdog.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      S_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = C_WAIT_ONE;
        end
      end
      S_MEM_WAIT: begin
        if (w_mem_ack) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == C_WAIT_MAX) begin
          state_d       = S_ERROR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_ERROR: begin
        // Trapped until reset.
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Prioritised per-stage controls; all forced low while reset is asserted.
  always_comb begin
    w_ctl = C_CTL_NONE;
    if (!rst_n) begin
      w_ctl = C_CTL_NONE;
    end else if (w_mem_stall) begin
      w_ctl = C_CTL_MEM_STALL;
    end else if (bus.branch_taken) begin
      // The ID instruction is squashed, so a coincident hazard is moot.
      w_ctl = C_CTL_BRANCH;
    end else if (bus.hazard_detected) begin
      w_ctl = C_CTL_HAZARD;
    end
  end

  assign bus.pc_freeze    = w_ctl.pc_freeze;
  assign bus.if_id_freeze = w_ctl.if_id_freeze;
  assign bus.if_id_flush  = w_ctl.if_id_flush;
  assign bus.id_ex_bubble = w_ctl.id_ex_bubble;
  assign bus.pipe_freeze  = w_ctl.pipe_freeze;
  assign bus.mem_timeout  = mem_timeout_q;

  assign w_stall_inc = w_ctl.pc_freeze | w_ctl.pipe_freeze;
  assign w_flush_inc = w_ctl.if_id_flush;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (bus.stall_cycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (bus.flush_events)
  );

endmodule : pipeline_stall_ctrl
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_ctrl
//  Description : Self-checking bench for pipeline_stall_ctrl. Expected
//                control words are queued as stimulus is applied and popped
//                when the DUT outputs are sampled on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 3;

  // Control word order: {pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_MEM  = 5'b11001;
  localparam logic [4:0] E_BR   = 5'b00110;
  localparam logic [4:0] E_HAZ  = 5'b11010;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  logic [4:0] exp_q[$];

  pipeline_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] get_ctl();
    return {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush,
            bus.id_ex_bubble, bus.pipe_freeze};
  endfunction

  // Apply {hazard, branch, mem_req, mem_ready} just after a rising edge.
  task automatic apply(input logic [3:0] s);
    @(posedge clk);
    #1;
    {bus.hazard_detected, bus.branch_taken, bus.mem_req, bus.mem_ready} = s;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    {bus.hazard_detected, bus.branch_taken, bus.mem_req, bus.mem_ready} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] got, exp;
    rst_n = 1'b0;
    {bus.hazard_detected, bus.branch_taken, bus.mem_req, bus.mem_ready} = 4'b1010;
    repeat (2) @(posedge clk);
    exp_q.push_back(E_NONE);
    @(negedge clk);
    got = get_ctl();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_ctl: got %b want %b", got, exp); end
    total++;
    if (bus.mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", bus.mem_timeout); end
    total++;
    if (bus.stall_cycles !== 3'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cycles); end
    total++;
    if (bus.flush_events !== 3'd0) begin bad++; $display("FAIL reset_flush_cnt: got %0d want 0", bus.flush_events); end
    {bus.hazard_detected, bus.branch_taken, bus.mem_req, bus.mem_ready} = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_hazard();
    logic [3:0] stim [2] = '{4'b1000, 4'b0000};
    logic [4:0] expv [2] = '{E_HAZ, E_NONE};
    logic [4:0] got, exp;
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      apply(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = get_ctl();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL hazard step%0d: got %b want %b", i, got, exp); end
    end
    total++;
    if (bus.stall_cycles !== 3'd1) begin bad++; $display("FAIL hazard_stall_cnt: got %0d want 1", bus.stall_cycles); end
    total++;
    if (bus.flush_events !== 3'd0) begin bad++; $display("FAIL hazard_flush_cnt: got %0d want 0", bus.flush_events); end
  endtask

  task automatic test_branch_hazard();
    logic [3:0] stim [2] = '{4'b1100, 4'b0000};
    logic [4:0] expv [2] = '{E_BR, E_NONE};
    logic [4:0] got, exp;
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      apply(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = get_ctl();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL branch step%0d: got %b want %b", i, got, exp); end
    end
    total++;
    if (bus.flush_events !== 3'd1) begin bad++; $display("FAIL branch_flush_cnt: got %0d want 1", bus.flush_events); end
    total++;
    if (bus.stall_cycles !== 3'd0) begin bad++; $display("FAIL branch_stall_cnt: got %0d want 0", bus.stall_cycles); end
  endtask

  task automatic test_mem_wait();
    // RUN hit, three wait cycles, completion, then idle (must be RUN again).
    logic [3:0] stim [6] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000};
    logic [4:0] expv [6] = '{E_NONE, E_MEM, E_MEM, E_MEM, E_NONE, E_NONE};
    logic [4:0] got, exp;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      apply(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = get_ctl();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL mem_wait step%0d: got %b want %b", i, got, exp); end
    end
    total++;
    if (bus.stall_cycles !== 3'd3) begin bad++; $display("FAIL mem_wait_stall_cnt: got %0d want 3", bus.stall_cycles); end
  endtask

  task automatic test_mem_priority();
    // Hazard/branch ignored under a memory stall; branch wins on release.
    logic [3:0] stim [4] = '{4'b1110, 4'b0110, 4'b1111, 4'b0000};
    logic [4:0] expv [4] = '{E_MEM, E_MEM, E_BR, E_NONE};
    logic [4:0] got, exp;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      apply(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = get_ctl();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL mem_prio step%0d: got %b want %b", i, got, exp); end
    end
    total++;
    if (bus.stall_cycles !== 3'd2) begin bad++; $display("FAIL mem_prio_stall_cnt: got %0d want 2", bus.stall_cycles); end
    total++;
    if (bus.flush_events !== 3'd1) begin bad++; $display("FAIL mem_prio_flush_cnt: got %0d want 1", bus.flush_events); end
  endtask

  task automatic test_timeout();
    // Five stalled cycles reach ERROR; it holds regardless of later inputs.
    logic [3:0] stim [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                             4'b1101, 4'b0011, 4'b0000};
    logic [4:0] expv [8] = '{E_MEM, E_MEM, E_MEM, E_MEM, E_MEM, E_MEM, E_MEM, E_MEM};
    logic       exp_to [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] got, exp;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      apply(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = get_ctl();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL timeout step%0d: got %b want %b", i, got, exp); end
      total++;
      if (bus.mem_timeout !== exp_to[i]) begin
        bad++; $display("FAIL timeout_flag step%0d: got %b want %b", i, bus.mem_timeout, exp_to[i]);
      end
    end
    total++;
    if (bus.stall_cycles !== 3'd7) begin bad++; $display("FAIL timeout_stall_cnt: got %0d want 7", bus.stall_cycles); end
    // Reset away from any clock edge clears everything at once.
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back(E_NONE);
    got = get_ctl();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL timeout_rst_ctl: got %b want %b", got, exp); end
    total++;
    if (bus.mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_rst_flag: got %b want 0", bus.mem_timeout); end
    total++;
    if (bus.stall_cycles !== 3'd0) begin bad++; $display("FAIL timeout_rst_cnt: got %0d want 0", bus.stall_cycles); end
    {bus.hazard_detected, bus.branch_taken, bus.mem_req, bus.mem_ready} = 4'b0000;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    logic [4:0] got, exp;
    int         want;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      apply(4'b1000);
      exp_q.push_back(E_HAZ);
      @(negedge clk);
      got = get_ctl();
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL sat_haz step%0d: got %b want %b", i, got, exp); end
      want = (i < 7) ? i : 7;
      total++;
      if (bus.stall_cycles !== TB_CNT_W'(want)) begin
        bad++; $display("FAIL sat_stall step%0d: got %0d want %0d", i, bus.stall_cycles, want);
      end
    end
    apply(4'b0000);
    @(negedge clk);
    total++;
    if (bus.stall_cycles !== 3'd7) begin bad++; $display("FAIL sat_stall_final: got %0d want 7", bus.stall_cycles); end
    // Flush counter saturates independently.
    for (int i = 0; i < 9; i++) apply(4'b0100);
    apply(4'b0000);
    @(negedge clk);
    total++;
    if (bus.flush_events !== 3'd7) begin bad++; $display("FAIL sat_flush_final: got %0d want 7", bus.flush_events); end
    total++;
    if (bus.stall_cycles !== 3'd7) begin bad++; $display("FAIL sat_stall_hold: got %0d want 7", bus.stall_cycles); end
  endtask

  task automatic test_async_reset();
    // Two stall cycles put the DUT in MEM_WAIT, then an asynchronous reset.
    logic [4:0] got, exp;
    reset_dut();
    apply(4'b0010);
    apply(4'b0010);
    exp_q.push_back(E_MEM);
    @(negedge clk);
    got = get_ctl();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL async_pre: got %b want %b", got, exp); end
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back(E_NONE);
    got = get_ctl();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL async_ctl: got %b want %b", got, exp); end
    total++;
    if (bus.stall_cycles !== 3'd0) begin bad++; $display("FAIL async_cnt: got %0d want 0", bus.stall_cycles); end
    {bus.hazard_detected, bus.branch_taken, bus.mem_req, bus.mem_ready} = 4'b0000;
    #1 rst_n = 1'b1;
    // Idle inputs would still freeze if the DUT were stuck in MEM_WAIT.
    apply(4'b0000);
    exp_q.push_back(E_NONE);
    @(negedge clk);
    got = get_ctl();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL async_run: got %b want %b", got, exp); end
    apply(4'b0011);
    exp_q.push_back(E_NONE);
    @(negedge clk);
    got = get_ctl();
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL async_hit: got %b want %b", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {bus.hazard_detected, bus.branch_taken, bus.mem_req, bus.mem_ready} = 4'b0000;
    test_reset();
    test_hazard();
    test_branch_hazard();
    test_mem_wait();
    test_mem_priority();
    test_timeout();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipeline_stall_ctrl
`default_nettype wire
